hypot_sched: RTL and testbench

Round-robin scheduler that shares one sequential magnitude engine (sqrt(x^2+y^2): repeated-add squaring followed by a bitwise square root) between two requesters. It accepts operand pairs over valid/ready, issues a one-cycle start to the engine and waits for done under a watchdog. It then returns the result tagged with the requester ID over valid/ready. It sits between the tile I/O front end and the engine instance in the top level.

---
 rtl/hypot_pkg.sv | 19 +
 rtl/rr_arb2.sv | 15 +
 rtl/hypot_sched.sv | 115 +++++++++++
 tb/tb_hypot_sched.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hypot_pkg.sv
// Shared types and defaults for the hypot scheduler.
// Holds the FSM state encoding, width/timeout defaults and the error result.
package hypot_pkg;

  localparam int DW_DEF      = 8;
  localparam int RW_DEF      = 8;
  localparam int TIMEOUT_DEF = 600;
  localparam int TW_DEF      = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } state_t;

  localparam logic [RW_DEF-1:0] RESULT_ERR = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: last (previous winner), req (valids), gnt (one-hot grant).
module rr_arb2 (
  input  logic       last,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the side that did not win last time goes next.
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/hypot_sched.sv
// Shares one magnitude engine between two requesters, with watchdog.
// Ports: r0/r1 request channels, eng_* engine side, rsp_* tagged result.
module hypot_sched
  import hypot_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [DW-1:0] r0_x,
  input  logic [DW-1:0] r0_y,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [DW-1:0] r1_x,
  input  logic [DW-1:0] r1_y,
  output logic          eng_start,
  output logic [DW-1:0] eng_x,
  output logic [DW-1:0] eng_y,
  input  logic          eng_done,
  input  logic [RW-1:0] eng_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy
);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] cnt;
  logic          last_grant;
  logic          cur_id;
  logic [1:0]    gnt;
  logic          open;
  logic          take;

  rr_arb2 u_arb (
    .last (last_grant),
    .req  ({r1_valid, r0_valid}),
    .gnt  (gnt)
  );

  // rst_n gating keeps ready low while reset is held.
  assign open      = rst_n & ena & (state == S_IDLE);
  assign r0_ready  = open & gnt[0];
  assign r1_ready  = open & gnt[1];
  assign take      = r0_ready | r1_ready;
  assign eng_start = ena & (state == S_ISSUE);
  assign rsp_id    = cur_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      eng_x      <= '0;
      eng_y      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (take) begin
            eng_x      <= gnt[1] ? r1_x : r0_x;
            eng_y      <= gnt[1] ? r1_y : r0_y;
            cur_id     <= gnt[1];
            last_grant <= gnt[1];
            state      <= S_ISSUE;
            busy       <= 1'b1;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done outranks a timeout landing in the same cycle
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_DELIVER;
          end else if (cnt == TMO_LAST) begin
            rsp_data  <= {RW{RESULT_ERR[0]}};
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_DELIVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_sched.sv
// Self-checking bench for hypot_sched with a behavioural engine model.
// Drives at posedge+1, samples at negedge.
module tb_hypot_sched;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       r0_valid, r0_ready;
  logic [7:0] r0_x, r0_y;
  logic       r1_valid, r1_ready;
  logic [7:0] r1_x, r1_y;
  logic       eng_start;
  logic [7:0] eng_x, eng_y;
  logic       eng_done;
  logic [7:0] eng_result;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_data;

  int n_chk  = 0;
  int n_pass = 0;

  hypot_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_x       (r0_x),
    .r0_y       (r0_y),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_x       (r1_x),
    .r1_y       (r1_y),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [7:0] mag(input logic [7:0] x, input logic [7:0] y);
    int vx = x;
    int vy = y;
    return 8'(isqrt(vx * vx + vy * vy));
  endfunction

  // Engine model: start -> done after eng_lat enabled cycles (-1: never).
  int         eng_lat    = 10;
  int         eng_left   = 0;
  int         stray_req  = 0;
  int         stray_done = 0;
  logic [7:0] eng_pend   = 8'h00;

  initial begin
    eng_done   = 1'b0;
    eng_result = 8'h00;
  end

  always begin
    @(posedge clk);
    #2;
    eng_done = 1'b0;
    if (!rst_n) begin
      eng_left = 0;
    end else if (ena) begin
      if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin
          eng_done   = 1'b1;
          eng_result = eng_pend;
        end
      end
      if (eng_start) begin
        eng_pend = mag(eng_x, eng_y);
        eng_left = (eng_lat < 0) ? 0 : eng_lat;
      end
    end
    if (stray_req != stray_done) begin
      stray_done++;
      eng_done   = 1'b1;
      eng_result = 8'h77;
    end
  end

  int         acc_ids[$];
  logic       rsp_i[$];
  logic [7:0] rsp_d[$];
  logic       rsp_e[$];

  typedef struct {
    logic       id;
    logic [7:0] d;
  } exp_t;

  task automatic clear_q();
    acc_ids.delete();
    rsp_i.delete();
    rsp_d.delete();
    rsp_e.delete();
  endtask

  task automatic do_reset();
    r0_valid  = 0;
    r1_valid  = 0;
    rsp_ready = 0;
    ena       = 1;
    rst_n     = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Present one request, let it be accepted, end at the ISSUE negedge.
  task automatic issue(input logic id, input logic [7:0] x, input logic [7:0] y);
    if (id) begin
      r1_x = x; r1_y = y; r1_valid = 1;
    end else begin
      r0_x = x; r0_y = y; r0_valid = 1;
    end
    @(posedge clk);
    #1;
    r0_valid = 0;
    r1_valid = 0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int maxc, output int t);
    t = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (rsp_valid) begin
        t = c;
        break;
      end
    end
  endtask

  task automatic pump(input int n, input int maxc, input bit drop, output bit to);
    int got = 0;
    bit a0, a1;
    to = 1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (a0) acc_ids.push_back(0);
      if (a1) acc_ids.push_back(1);
      if (rsp_valid && rsp_ready) begin
        rsp_i.push_back(rsp_id);
        rsp_d.push_back(rsp_data);
        rsp_e.push_back(rsp_err);
        got++;
      end
      @(posedge clk);
      #1;
      if (drop && a0) r0_valid = 0;
      if (drop && a1) r1_valid = 0;
      if (got == n) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; rsp_ready = 0;
    r0_valid = 1; r1_valid = 1;
    r0_x = 8'h12; r0_y = 8'h34; r1_x = 8'h56; r1_y = 8'h78;
    #3;
    n_chk++;
    if ({r0_ready, r1_ready, eng_start} !== 3'b000)
      $display("FAIL reset_ready_start: got %b want 000", {r0_ready, r1_ready, eng_start});
    else n_pass++;
    n_chk++;
    if ({eng_x, eng_y} !== 16'h0)
      $display("FAIL reset_eng_xy: got %h want 0000", {eng_x, eng_y});
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_err, busy, rsp_data} !== 12'h0)
      $display("FAIL reset_rsp_busy: got %h want 000", {rsp_valid, rsp_id, rsp_err, busy, rsp_data});
    else n_pass++;
    r0_valid = 0; r1_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int t;
    eng_lat = 10; rsp_ready = 1;
    r0_x = 3; r0_y = 4; r0_valid = 1;
    @(negedge clk);
    n_chk++;
    if ({r0_ready, r1_ready} !== 2'b10)
      $display("FAIL single_ready: got %b want 10", {r0_ready, r1_ready});
    else n_pass++;
    @(posedge clk);
    #1 r0_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({eng_start, eng_x, eng_y} !== {1'b1, 8'd3, 8'd4})
      $display("FAIL single_start: got %h want 10304", {eng_start, eng_x, eng_y});
    else n_pass++;
    wait_rsp(100, t);
    n_chk++;
    if (t !== 11) $display("FAIL single_latency: got %0d want 11", t);
    else n_pass++;
    n_chk++;
    if ({rsp_id, rsp_data, rsp_err} !== {1'b0, 8'd5, 1'b0})
      $display("FAIL single_rsp: got %h want 00a", {rsp_id, rsp_data, rsp_err});
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL single_idle: got %b want 00", {rsp_valid, busy});
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie();
    bit to;
    do_reset();
    clear_q();
    eng_lat = 4; rsp_ready = 1;
    r0_x = 6; r0_y = 8; r1_x = 5; r1_y = 12;
    r0_valid = 1; r1_valid = 1;
    pump(2, 200, 1, to);
    n_chk++;
    if (to !== 1'b0 || acc_ids.size() != 2 || rsp_d.size() != 2)
      $display("FAIL tie_count: got to=%0d acc=%0d rsp=%0d want 0 2 2", to, acc_ids.size(), rsp_d.size());
    else begin
      n_pass++;
      n_chk++;
      if (acc_ids[0] !== 0 || acc_ids[1] !== 1)
        $display("FAIL tie_order: got %0d,%0d want 0,1", acc_ids[0], acc_ids[1]);
      else n_pass++;
      n_chk++;
      if ({rsp_i[0], rsp_d[0], rsp_e[0]} !== {1'b0, 8'd10, 1'b0})
        $display("FAIL tie_rsp0: got %h want 014", {rsp_i[0], rsp_d[0], rsp_e[0]});
      else n_pass++;
      n_chk++;
      if ({rsp_i[1], rsp_d[1], rsp_e[1]} !== {1'b1, 8'd13, 1'b0})
        $display("FAIL tie_rsp1: got %h want 21a", {rsp_i[1], rsp_d[1], rsp_e[1]});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int ones = 0;
    logic [7:0] e0, e1;
    do_reset();
    clear_q();
    eng_lat = 3; rsp_ready = 1;
    r0_x = 8'($urandom_range(0, 179)); r0_y = 8'($urandom_range(0, 179));
    r1_x = 8'($urandom_range(0, 179)); r1_y = 8'($urandom_range(0, 179));
    e0 = mag(r0_x, r0_y);
    e1 = mag(r1_x, r1_y);
    r0_valid = 1; r1_valid = 1;
    pump(4, 400, 0, to);
    r0_valid = 0; r1_valid = 0;
    n_chk++;
    if (to !== 1'b0 || acc_ids.size() != 4 || rsp_d.size() != 4)
      $display("FAIL b2b_count: got to=%0d acc=%0d rsp=%0d want 0 4 4", to, acc_ids.size(), rsp_d.size());
    else begin
      n_pass++;
      foreach (acc_ids[i]) ones += acc_ids[i];
      n_chk++;
      if (ones != 2) $display("FAIL b2b_ready_pulses: got %0d want 2", ones);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (acc_ids[i] !== (i % 2) || rsp_i[i] !== 1'(i % 2) ||
            rsp_d[i] !== ((i % 2) ? e1 : e0) || rsp_e[i] !== 1'b0)
          $display("FAIL b2b_txn%0d: got id %0d/%0d data %h want id %0d data %h",
                   i, acc_ids[i], rsp_i[i], rsp_d[i], i % 2, (i % 2) ? e1 : e0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    int t;
    eng_lat = -1; rsp_ready = 1;
    issue(0, 10, 20);
    n_chk++;
    if (eng_start !== 1'b1) $display("FAIL tmo_start: got %b want 1", eng_start);
    else n_pass++;
    wait_rsp(800, t);
    n_chk++;
    if (t !== 601) $display("FAIL tmo_latency: got %0d want 601", t);
    else n_pass++;
    n_chk++;
    if ({rsp_id, rsp_data, rsp_err} !== {1'b0, 8'hFF, 1'b1})
      $display("FAIL tmo_rsp: got %h want 1ff", {rsp_id, rsp_data, rsp_err});
    else n_pass++;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    stray_req++;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if ({busy, rsp_valid} !== 2'b00)
      $display("FAIL tmo_stray: got %b want 00", {busy, rsp_valid});
    else n_pass++;
    @(posedge clk);
    #1;
    eng_lat = 7;
    issue(1, 9, 12);
    wait_rsp(50, t);
    n_chk++;
    if (t !== 8 || {rsp_id, rsp_data, rsp_err} !== {1'b1, 8'd15, 1'b0})
      $display("FAIL tmo_next: got t=%0d %h want t=8 21e", t, {rsp_id, rsp_data, rsp_err});
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int t;
    int bad = 0;
    eng_lat = 2; rsp_ready = 0;
    issue(1, 7, 24);
    wait_rsp(20, t);
    n_chk++;
    if (t !== 3 || {rsp_id, rsp_data, rsp_err} !== {1'b1, 8'd25, 1'b0})
      $display("FAIL stall_rsp: got t=%0d %h want t=3 232", t, {rsp_id, rsp_data, rsp_err});
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      r0_valid = 1; r1_valid = 1;
      r0_x = 8'($urandom); r1_y = 8'($urandom);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'd25 ||
          r0_ready !== 1'b0 || r1_ready !== 1'b0 || eng_start !== 1'b0)
        bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0; rsp_ready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL stall_release: got %b want 00", {rsp_valid, busy});
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ena_pause();
    int t;
    int bad = 0;
    eng_lat = -1; rsp_ready = 1;
    issue(0, 1, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      ena = 0; r0_valid = 1;
      if (c == 0) stray_req++;
      @(negedge clk);
      if (eng_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || r0_ready !== 1'b0)
        bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL ena_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    @(posedge clk);
    #1;
    ena = 1; r0_valid = 0;
    @(negedge clk);
    wait_rsp(800, t);
    n_chk++;
    if (t !== 595 || {rsp_data, rsp_err} !== {8'hFF, 1'b1})
      $display("FAIL ena_resume: got t=%0d %h want t=595 1ff", t, {rsp_data, rsp_err});
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    exp_t       q[$];
    exp_t       e;
    bit         pend[2];
    logic [7:0] px[2], py[2];
    bit         midle = 1;
    bit         mlast = 1;
    bit         g0, g1;
    int         done = 0;
    int         bad_rdy = 0;
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 4000 && done < 24; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          px[i] = 8'($urandom_range(0, 179));
          py[i] = 8'($urandom_range(0, 179));
        end
      r0_valid = pend[0]; r0_x = px[0]; r0_y = py[0];
      r1_valid = pend[1]; r1_x = px[1]; r1_y = py[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      eng_lat = $urandom_range(1, 30);
      @(negedge clk);
      g0 = pend[0] && (!pend[1] || mlast);
      g1 = pend[1] && (!pend[0] || !mlast);
      n_chk++;
      if ({r0_ready, r1_ready} !== {midle && g0, midle && g1}) begin
        bad_rdy++;
        if (bad_rdy < 5)
          $display("FAIL rand_ready: got %b want %b", {r0_ready, r1_ready}, {midle && g0, midle && g1});
      end else n_pass++;
      if (midle && (g0 || g1)) begin
        e.id = g1;
        e.d  = mag(px[g1], py[g1]);
        q.push_back(e);
        mlast = g1;
        midle = 0;
        pend[g1] = 0;
      end
      if (rsp_valid && rsp_ready) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rand_spurious: got rsp want none");
        else begin
          e = q.pop_front();
          if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.d, 1'b0})
            $display("FAIL rand_rsp: got %h want %h", {rsp_id, rsp_data, rsp_err}, {e.id, e.d, 1'b0});
          else n_pass++;
        end
        done++;
        midle = 1;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (done < 24) $display("FAIL rand_progress: got %0d want 24", done);
    else n_pass++;
    r0_valid = 0; r1_valid = 0;
  endtask

  task automatic test_reset_midwait();
    bit to;
    do_reset();
    eng_lat = 50; rsp_ready = 1;
    issue(0, 2, 3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    r0_valid = 1; r1_valid = 1;
    r0_x = 8'd8; r0_y = 8'd15;
    rst_n = 0;
    #1;
    n_chk++;
    if ({r0_ready, r1_ready, eng_start, busy, rsp_valid, rsp_id, rsp_err} !== 7'b0 ||
        {eng_x, eng_y, rsp_data} !== 24'h0)
      $display("FAIL midwait_reset: got %b %h want 0 0",
               {r0_ready, r1_ready, eng_start, busy, rsp_valid, rsp_id, rsp_err},
               {eng_x, eng_y, rsp_data});
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_chk++;
    if ({r0_ready, r1_ready} !== 2'b10)
      $display("FAIL midwait_tie: got %b want 10", {r0_ready, r1_ready});
    else n_pass++;
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0;
    eng_lat = 5;
    clear_q();
    pump(1, 200, 0, to);
    n_chk++;
    if (to !== 1'b0 || rsp_d.size() != 1 || {rsp_i[0], rsp_d[0], rsp_e[0]} !== {1'b0, 8'd17, 1'b0})
      $display("FAIL midwait_after: got to=%0d n=%0d want 0 1 data 11", to, rsp_d.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 0; ena = 1; rsp_ready = 0;
    r0_valid = 0; r1_valid = 0;
    r0_x = 0; r0_y = 0; r1_x = 0; r1_y = 0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_stall();
    test_ena_pause();
    test_random();
    test_reset_midwait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
